// File: rtl/alu_pkg.sv
// Opcodes, issuer FSM states and the command payload layout shared by the issuer and the ALU tile.
// Pure definitions: no latency or flow control of its own.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    localparam int CMD_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    // Commands the ALU must never see: undefined opcodes and divide by zero.
    function automatic logic cmd_is_err(input cmd_t cmd);
        return (cmd.op[2:1] == 2'b11) || ((cmd.op == OP_DIV) && (cmd.b == 4'd0));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: writes are dropped while full, reads are ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push;
    logic             pop;

    assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign push   = wr_vld && !full;
    assign pop    = rd_en && !empty;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues host ALU commands, issues them one at a time to the ALU tile and returns tagged results.
// Latency: response valid 3+ALU_LATENCY cycles after acceptance (2 for screened errors).
// Backpressure: cmd_ready drops when the FIFO is full; a response holds until rsp_ready.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int FIFO_W = CMD_W + TAG_W;
    localparam int CNT_W  = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    cmd_t             in_cmd;
    cmd_t             pop_cmd;
    logic [TAG_W-1:0] pop_tag;
    logic [FIFO_W-1:0] fifo_rd_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             push;

    assign in_cmd    = {cmd_op, cmd_a, cmd_b};
    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign {pop_tag, pop_cmd} = fifo_rd_dat;

    // The tag travels with the command so responses carry acceptance order.
    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat ({tag_cnt_q, in_cmd}),
        .full   (fifo_full),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tag_cnt_d  = tag_cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_tag_d  = rsp_tag_q;
        fifo_pop   = 1'b0;

        if (push) begin
            tag_cnt_d = tag_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    rsp_tag_d = pop_tag;
                    if (cmd_is_err(pop_cmd)) begin
                        rsp_data_d = 8'hFF;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        alu_a_d    = pop_cmd.a;
                        alu_b_d    = pop_cmd.b;
                        alu_op_d   = pop_cmd.op;
                        wait_cnt_d = CNT_INIT;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tag_cnt_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tag_cnt_q  <= tag_cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed and randomized commands against a queue-based reference model,
// with a behavioural one-cycle ALU tile answering the issuer's alu_* outputs.
module tb_alu_cmd_issuer;

    typedef struct packed {
        logic [3:0] tag;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] rsp_tag;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    logic [3:0] mt = '0;
    logic ready_log [8];
    int   rsp_cyc [64];

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag)
    );

    // ALU tile stand-in: one registered stage; junk for inputs the issuer should never send.
    always @(posedge clk) begin
        case (alu_op)
            3'd0:    alu_result <= {4'h0, alu_a & alu_b};
            3'd1:    alu_result <= {4'h0, alu_a | alu_b};
            3'd2:    alu_result <= {4'h0, alu_a} + {4'h0, alu_b};
            3'd3:    alu_result <= {4'h0, alu_a} - {4'h0, alu_b};
            3'd4:    alu_result <= {4'h0, alu_a} * {4'h0, alu_b};
            3'd5:    alu_result <= (alu_b == 4'd0) ? 8'hEE : {4'h0, alu_a / alu_b};
            default: alu_result <= 8'hAA;
        endcase
    end

    // Expected {err, data} from the command's arithmetic meaning.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        ia = {28'd0, a};
        ib = {28'd0, b};
        r  = 0;
        case (op)
            3'd0: r = ia & ib;
            3'd1: r = ia | ib;
            3'd2: r = ia + ib;
            3'd3: r = (ia - ib) & 255;
            3'd4: r = ia * ib;
            3'd5: begin
                if (ib == 0) return {1'b1, 8'hFF};
                r = ia / ib;
            end
            default: return {1'b1, 8'hFF};
        endcase
        return {1'b0, r[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        q.delete();
        mt = '0;
        @(negedge clk);
    endtask

    // One command into an idle, empty issuer; checks latency, alu_* drive and the response.
    task automatic single(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [8:0] r;
        logic [3:0] pa;
        logic [3:0] pb;
        logic [2:0] po;
        int         n;
        r  = ref_alu(op, a, b);
        pa = alu_a;
        pb = alu_b;
        po = alu_op;
        rsp_ready = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        chk("single_cmd_ready", 32'(cmd_ready), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
            if (n == 2) begin
                chk("single_alu_a", 32'(alu_a), r[8] ? 32'(pa) : 32'(a));
                chk("single_alu_b", 32'(alu_b), r[8] ? 32'(pb) : 32'(b));
                chk("single_alu_op", 32'(alu_op), r[8] ? 32'(po) : 32'(op));
            end
        end while (!rsp_valid && n < 20);
        chk("single_latency", 32'(n), r[8] ? 32'd2 : 32'd4);
        chk("single_data", 32'(rsp_data), 32'(r[7:0]));
        chk("single_err", 32'(rsp_err), 32'(r[8]));
        chk("single_tag", 32'(rsp_tag), 32'(mt));
        mt = mt + 1'b1;
        @(negedge clk);
        chk("single_rsp_consumed", 32'(rsp_valid), 32'd0);
    endtask

    // Streams ncmd commands (kind 0: any op, kind 1: OR only) and checks every response in order.
    task automatic run_stream(input int ncmd, input int kind, input int hold, input bit rnd_ready);
        int         sent;
        int         got;
        int         cyc;
        logic       have;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       held;
        logic [7:0] hd;
        logic       he;
        logic [3:0] ht;
        exp_t       e;
        sent = 0; got = 0; cyc = 0; have = 1'b0; held = 1'b0;
        op = '0; a = '0; b = '0; hd = '0; he = 1'b0; ht = '0;
        while (got < ncmd && cyc < 2000) begin
            if (!have && sent < ncmd) begin
                op   = (kind == 1) ? 3'd1 : 3'($urandom_range(0, 7));
                a    = 4'($urandom_range(0, 15));
                b    = 4'($urandom_range(0, 15));
                have = 1'b1;
            end
            cmd_valid = have;
            cmd_op    = op;
            cmd_a     = a;
            cmd_b     = b;
            rsp_ready = (cyc < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (cyc < 8) ready_log[cyc] = cmd_ready;
            if (held) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", 32'(rsp_data), 32'(hd));
                chk("hold_err", 32'(rsp_err), 32'(he));
                chk("hold_tag", 32'(rsp_tag), 32'(ht));
            end
            if (cmd_valid && cmd_ready) begin
                q.push_back({mt, ref_alu(op, a, b)});
                mt   = mt + 1'b1;
                sent++;
                have = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                chk("stream_rsp_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("stream_data", 32'(rsp_data), 32'(e.data));
                    chk("stream_err", 32'(rsp_err), 32'(e.err));
                    chk("stream_tag", 32'(rsp_tag), 32'(e.tag));
                end
                if (got < 64) rsp_cyc[got] = cyc;
                got++;
            end
            held = rsp_valid && !rsp_ready;
            hd   = rsp_data;
            he   = rsp_err;
            ht   = rsp_tag;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("stream_all_rsp", 32'(got), 32'(ncmd));
        chk("stream_queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        single(3'd0, 4'hC, 4'hA);
        single(3'd2, 4'hF, 4'hF);
        single(3'd3, 4'h3, 4'h5);
        single(3'd4, 4'hF, 4'hF);
        single(3'd5, 4'hE, 4'h3);
        single(3'd5, 4'h7, 4'h0);
        single(3'd6, 4'h9, 4'h2);
        single(3'd7, 4'h1, 4'h4);
        for (int i = 0; i < 6; i++) begin
            single(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        do_reset();
        run_stream(6, 0, 16, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_cmd_ready", 32'(ready_log[i]), (i < 5) ? 32'd1 : 32'd0);
        end

        do_reset();
        run_stream(20, 1, 0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            chk("or_issue_interval", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd4);
        end

        do_reset();
        run_stream(40, 0, 0, 1'b1);

        do_reset();
        cmd_valid = 1'b1;
        cmd_op = 3'd2; cmd_a = 4'h5; cmd_b = 4'h6;
        @(negedge clk);
        cmd_op = 3'd1; cmd_a = 4'h3; cmd_b = 4'h8;
        @(negedge clk);
        cmd_op = 3'd4; cmd_a = 4'h2; cmd_b = 4'h7;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_busy_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_alu_a_loaded", 32'(alu_a), 32'h5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        q.delete();
        mt = '0;
        @(negedge clk);
        single(3'd0, 4'h1, 4'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
